// File: rtl/axi4l_pkg.sv
// axi4l_pkg: AXI4-Lite response codes and the engine state encodings
// shared by the IPIF master and its bench.
package axi4l_pkg;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
endpackage

// File: rtl/axi4l_ipif_master.sv
// axi4l_ipif_master: turns single-cycle local read/write requests into AXI4-Lite
// transactions; independent write and read engines, one outstanding each.
module axi4l_ipif_master
    import axi4l_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 12,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [C_ADDR_WIDTH-3:0] wr_addr,
    input  logic                    wr_req,
    input  logic [3:0]              wr_be,
    input  logic [C_DATA_WIDTH-1:0] wr_data,
    output logic                    wr_ack,
    output logic                    wr_err,
    output logic                    wr_busy,
    input  logic [C_ADDR_WIDTH-3:0] rd_addr,
    input  logic                    rd_req,
    output logic [C_DATA_WIDTH-1:0] rd_data,
    output logic                    rd_ack,
    output logic                    rd_err,
    output logic                    rd_busy,
    output logic [31:0]             m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [C_DATA_WIDTH-1:0] m_axi_wdata,
    output logic [3:0]              m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [31:0]             m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [C_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);
    w_state_t                w_state, w_state_n;
    r_state_t                r_state, r_state_n;
    logic [31:0]             awaddr_n, araddr_n;
    logic [C_DATA_WIDTH-1:0] wdata_n, rd_data_n;
    logic [3:0]              wstrb_n;
    logic                    awvalid_n, wvalid_n, bready_n, wr_ack_n, wr_err_n, wr_busy_n;
    logic                    arvalid_n, rready_n, rd_ack_n, rd_err_n, rd_busy_n;
    logic                    unused_resp;

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    // only bit 1 of a response distinguishes errors from OKAY/EXOKAY
    assign unused_resp  = m_axi_bresp[0] ^ m_axi_rresp[0];

    always_comb begin
        w_state_n = w_state;
        awaddr_n  = m_axi_awaddr;
        wdata_n   = m_axi_wdata;
        wstrb_n   = m_axi_wstrb;
        awvalid_n = m_axi_awvalid;
        wvalid_n  = m_axi_wvalid;
        bready_n  = m_axi_bready;
        wr_ack_n  = 1'b0;
        wr_err_n  = 1'b0;
        case (w_state)
            W_IDLE: if (wr_req && !wr_ack) begin
                awaddr_n  = 32'({wr_addr, 2'b00});
                wdata_n   = wr_data;
                wstrb_n   = wr_be;
                awvalid_n = 1'b1;
                wvalid_n  = 1'b1;
                w_state_n = W_ADDR;
            end
            W_ADDR: begin
                awvalid_n = m_axi_awvalid && !m_axi_awready;
                wvalid_n  = m_axi_wvalid && !m_axi_wready;
                if (!awvalid_n && !wvalid_n) begin
                    bready_n  = 1'b1;
                    w_state_n = W_RESP;
                end
            end
            W_RESP: if (m_axi_bvalid) begin
                bready_n  = 1'b0;
                wr_ack_n  = 1'b1;
                wr_err_n  = m_axi_bresp[1];
                w_state_n = W_IDLE;
            end
            default: w_state_n = W_IDLE;
        endcase
        wr_busy_n = w_state_n != W_IDLE;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state       <= W_IDLE;
            m_axi_awaddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            wr_ack        <= 1'b0;
            wr_err        <= 1'b0;
            wr_busy       <= 1'b0;
        end else begin
            w_state       <= w_state_n;
            m_axi_awaddr  <= awaddr_n;
            m_axi_wdata   <= wdata_n;
            m_axi_wstrb   <= wstrb_n;
            m_axi_awvalid <= awvalid_n;
            m_axi_wvalid  <= wvalid_n;
            m_axi_bready  <= bready_n;
            wr_ack        <= wr_ack_n;
            wr_err        <= wr_err_n;
            wr_busy       <= wr_busy_n;
        end
    end

    always_comb begin
        r_state_n = r_state;
        araddr_n  = m_axi_araddr;
        arvalid_n = m_axi_arvalid;
        rready_n  = m_axi_rready;
        rd_data_n = rd_data;
        rd_ack_n  = 1'b0;
        rd_err_n  = 1'b0;
        case (r_state)
            R_IDLE: if (rd_req && !rd_ack) begin
                araddr_n  = 32'({rd_addr, 2'b00});
                arvalid_n = 1'b1;
                r_state_n = R_ADDR;
            end
            R_ADDR: if (m_axi_arready) begin
                arvalid_n = 1'b0;
                rready_n  = 1'b1;
                r_state_n = R_DATA;
            end
            R_DATA: if (m_axi_rvalid) begin
                rready_n  = 1'b0;
                rd_data_n = m_axi_rdata;
                rd_ack_n  = 1'b1;
                rd_err_n  = m_axi_rresp[1];
                r_state_n = R_IDLE;
            end
            default: r_state_n = R_IDLE;
        endcase
        rd_busy_n = r_state_n != R_IDLE;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= R_IDLE;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            rd_data       <= '0;
            rd_ack        <= 1'b0;
            rd_err        <= 1'b0;
            rd_busy       <= 1'b0;
        end else begin
            r_state       <= r_state_n;
            m_axi_araddr  <= araddr_n;
            m_axi_arvalid <= arvalid_n;
            m_axi_rready  <= rready_n;
            rd_data       <= rd_data_n;
            rd_ack        <= rd_ack_n;
            rd_err        <= rd_err_n;
            rd_busy       <= rd_busy_n;
        end
    end
endmodule

// File: doc/axi4l_ipif_master.md
AXI4L_IPIF_MASTER -- requirements
Module: axi4l_ipif_master

Interface
REQ-001 Parameters: C_ADDR_WIDTH, default 12, AXI byte-address width used; C_DATA_WIDTH, default 32, data width (only 32 supported).
REQ-002 One clock, aclk; reset is asynchronous and active-low, aresetn.
REQ-003 aclk  in  1  clock, all logic on rising edge.
REQ-004 aresetn  in  1  asynchronous active-low reset.
REQ-005 wr_addr  in  C_ADDR_WIDTH-2  local word address.
REQ-006 wr_req  in  1  single-cycle write request pulse.
REQ-007 wr_be  in  4  byte enables.
REQ-008 wr_data  in  C_DATA_WIDTH  write data.
REQ-009 wr_ack  out  1  single-cycle write completion pulse.
REQ-010 wr_err  out  1  valid with wr_ack; 1 = BRESP was SLVERR or DECERR.
REQ-011 wr_busy  out  1  write engine not idle.
REQ-012 rd_addr  in  C_ADDR_WIDTH-2  local word address.
REQ-013 rd_req  in  1  single-cycle read request pulse.
REQ-014 rd_data  out  C_DATA_WIDTH  read data, valid with rd_ack, held until the next rd_ack.
REQ-015 rd_ack  out  1  single-cycle read completion pulse.
REQ-016 rd_err  out  1  valid with rd_ack; 1 = RRESP[1] set.
REQ-017 rd_busy  out  1  read engine not idle.
REQ-018 m_axi_aw{addr 32, prot 3, valid 1} out, awready in; m_axi_w{data 32, strb 4, valid 1} out, wready in; m_axi_b{resp 2, valid 1} in, bready out; m_axi_ar{addr 32, prot 3, valid 1} out, arready in; m_axi_r{data 32, resp 2, valid 1} in, rready out.

Function
REQ-019 Write and read engines are fully independent and may be active in the same cycle.
REQ-020 AXI address = zero-extended {addr, 2'b00}; awprot/arprot constant 3'b000.
REQ-021 Write FSM states: W_IDLE, W_ADDR, W_RESP.
REQ-022 W_IDLE with wr_req=1: register addr/data/be; next cycle awvalid=wvalid=1; go W_ADDR.
REQ-023 W_ADDR: awvalid drops the cycle after the AW handshake and wvalid the cycle after the W handshake, independently; when both are done, go W_RESP.
REQ-024 W_RESP: bready=1; on bvalid, drop bready, pulse wr_ack for one cycle with wr_err=bresp[1], and return to W_IDLE.
REQ-025 Read FSM states: R_IDLE, R_ADDR, R_DATA.
REQ-026 R_IDLE with rd_req=1: register addr; next cycle arvalid=1; go R_ADDR.
REQ-027 R_ADDR: after the AR handshake drop arvalid and go R_DATA.
REQ-028 R_DATA: rready=1; on rvalid, capture rdata into rd_data, pulse rd_ack with rd_err=rresp[1], drop rready, and return to R_IDLE.
REQ-029 Latency with an always-ready slave: req at cycle N -> valid at N+1 -> bready/rready at N+2 -> ack at N+3 if the slave responds at N+2.
REQ-030 Once asserted, a VALID is held with address, data and strb stable until its handshake, per AXI.
REQ-031 Requests arriving while busy are ignored (no queueing); wr_busy/rd_busy rise the cycle after an accepted request and fall with ack.
REQ-032 A new request in the ack cycle is ignored; the earliest accepted request is one cycle after ack.
REQ-033 Stalls have no timeout: an engine waits indefinitely on ready/response.

Reset
REQ-034 aresetn=0 asynchronously forces both FSMs to IDLE and every output (all valids, readies, acks, errs, busys, rd_data, addresses, data, strb) to 0.
REQ-035 A reset mid-transaction abandons the transaction without generating an ack; the bench resets the slave with it.

Structure
REQ-036 Shared package axi4l_pkg holds the resp constants OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11 and the write/read state enums.
REQ-037 Single module with two FSM processes; no sub-module.

Verification
REQ-038 Loopback: wr 0x001 data 0xABCD_EF01 be 0xF, then rd 0x001 -> m_axi_awaddr 0x004, wr_ack, rd_data 0xABCD_EF01, errs 0.
REQ-039 Slave asserts awready 3 cycles before wready -> awvalid drops first, wvalid held stable, exactly one wr_ack.
REQ-040 Slave returns bresp=2'b10, then rresp=2'b11 -> wr_err=1, rd_err=1 on their acks.
REQ-041 Same-cycle wr_req and rd_req, plus an extra wr_req while wr_busy -> both complete, second write is dropped, one AW only.
REQ-042 bvalid delayed 20 cycles -> bready held, wr_busy=1 throughout, ack on the 21st cycle.
REQ-043 aresetn pulsed low during W_ADDR -> all outputs 0 immediately, no ack, next write completes normally.
